// File: rtl/cordic_pkg.sv
// Shared types and constants for the rec2pol CORDIC scheduler.
// Round-robin arbitration is enabled by defining CORDIC_SCHED_RR_EN.
package cordic_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned NITER_DEF = 32;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd2;
  localparam logic [STATE_W-1:0] ST_CAPT = 3'd3;
  localparam logic [STATE_W-1:0] ST_REJ  = 3'd4;

  localparam logic [DATA_W-1:0] Q16_ONE  = 32'h0001_0000;
  localparam logic [DATA_W-1:0] Q24_ONE  = 32'h0100_0000;
  localparam logic [DATA_W-1:0] XMAX_DEF = 32'h7FFF_0000;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } operand_t;

  typedef struct packed {
    logic [DATA_W-1:0] modulus;
    logic [DATA_W-1:0] angle;
  } result_t;

  // The core only converges for a strictly positive x below xmax.
  function automatic logic x_legal(input logic [DATA_W-1:0] x,
                                   input logic [DATA_W-1:0] xmax);
    return ($signed(x) > 0) && ($signed(x) < $signed(xmax));
  endfunction

endpackage

// File: rtl/sched_arbiter.sv
// Request arbiter: one-hot winner and its index; round-robin from ptr under
// CORDIC_SCHED_RR_EN, otherwise fixed priority with the lowest index winning.
module sched_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifdef CORDIC_SCHED_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  grant_c,
  output logic [IDX_W-1:0] idx_c
);

  logic found;
  int   cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
`ifdef CORDIC_SCHED_RR_EN
      cand = (int'(ptr) + k) % int'(NREQ);
`else
      cand = k;
`endif
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one rec2pol CORDIC core among NREQ requesters: arbitrate, latch
// operands, sequence start/enable, capture and return the tagged result.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int unsigned       NREQ  = 4,
  parameter int unsigned       NITER = NITER_DEF,
  parameter logic [DATA_W-1:0] XMAX  = XMAX_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] x_in,
  input  logic [DATA_W*NREQ-1:0] y_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      mod_out,
  output logic [DATA_W-1:0]      angle_out,
  output logic                   busy,
  output logic                   core_start,
  output logic                   core_enable,
  output logic [DATA_W-1:0]      core_x,
  output logic [DATA_W-1:0]      core_y,
  input  logic [DATA_W-1:0]      core_mod,
  input  logic [DATA_W-1:0]      core_angle
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(NITER);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  operand_t           op_q, op_d;
  result_t            res_q, res_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               enable_q, enable_d;

  logic [NREQ-1:0]    win_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [DATA_W-1:0]  x_arr [NREQ];
  logic [DATA_W-1:0]  y_arr [NREQ];

`ifdef CORDIC_SCHED_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign x_arr[i] = x_in[DATA_W*i +: DATA_W];
    assign y_arr[i] = y_in[DATA_W*i +: DATA_W];
  end

  sched_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
`ifdef CORDIC_SCHED_RR_EN
    .ptr     (ptr_q),
`endif
    .grant_c (win_c),
    .idx_c   (win_idx_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    res_d       = res_q;
    id_d        = id_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    start_d     = 1'b0;
    enable_d    = 1'b0;
`ifdef CORDIC_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = win_c;
          op_d.x  = x_arr[win_idx_c];
          op_d.y  = y_arr[win_idx_c];
          id_d    = win_idx_c;
          state_d = ST_LOAD;
`ifdef CORDIC_SCHED_RR_EN
          ptr_d   = (win_idx_c == IDX_W'(NREQ - 1)) ? '0 : win_idx_c + IDX_W'(1);
`endif
        end
      end
      ST_LOAD: begin
        if (x_legal(op_q.x, XMAX)) begin
          start_d  = 1'b1;
          enable_d = 1'b1;
          cnt_d    = CNT_W'(NITER - 1);
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_REJ;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d  = ST_CAPT;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          enable_d = 1'b1;
        end
      end
      ST_CAPT: begin
        res_d.modulus      = core_mod;
        res_d.angle        = core_angle;
        rsp_valid_d[id_q]  = 1'b1;
        state_d            = ST_IDLE;
      end
      ST_REJ: begin
        rsp_valid_d[id_q]  = 1'b1;
        rsp_err_d          = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      res_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      enable_q    <= 1'b0;
`ifdef CORDIC_SCHED_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      res_q       <= res_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      enable_q    <= enable_d;
`ifdef CORDIC_SCHED_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign mod_out     = res_q.modulus;
  assign angle_out   = res_q.angle;
  assign busy        = busy_q;
  assign core_start  = start_q;
  assign core_enable = enable_q;
  assign core_x      = op_q.x;
  assign core_y      = op_q.y;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a behavioural rec2pol stand-in plus a transaction-level
// reference of arbitration, latency and result capture.
module tb_cordic_sched;
  import cordic_pkg::*;

  localparam int NREQ  = 4;
  localparam int NITER = int'(NITER_DEF);

  logic                   clock;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [32*NREQ-1:0]     x_in;
  logic [32*NREQ-1:0]     y_in;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic                   rsp_err;
  logic [31:0]            mod_out;
  logic [31:0]            angle_out;
  logic                   busy;
  logic                   core_start;
  logic                   core_enable;
  logic [31:0]            core_x;
  logic [31:0]            core_y;
  logic [31:0]            core_mod;
  logic [31:0]            core_angle;

  int checks = 0;
  int errors = 0;

  cordic_sched #(.NREQ(NREQ), .NITER(NITER), .XMAX(XMAX_DEF)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .x_in        (x_in),
    .y_in        (y_in),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .mod_out     (mod_out),
    .angle_out   (angle_out),
    .busy        (busy),
    .core_start  (core_start),
    .core_enable (core_enable),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_mod    (core_mod),
    .core_angle  (core_angle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ideal polar conversion of a 16Q16 vector: modulus 16Q16, angle in degrees 8Q24.
  function automatic logic [31:0] ref_mod(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = $itor($signed(x)) / 65536.0;
    ry = $itor($signed(y)) / 65536.0;
    return 32'($rtoi($sqrt(rx * rx + ry * ry) * 65536.0));
  endfunction

  function automatic logic [31:0] ref_angle(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = $itor($signed(x)) / 65536.0;
    ry = $itor($signed(y)) / 65536.0;
    return 32'($rtoi($atan2(ry, rx) * 180.0 / 3.14159265358979 * 16777216.0));
  endfunction

  // Core stand-in: result is valid only after exactly NITER start/enable cycles.
  int unsigned core_n    = 0;
  int          unstable  = 0;
  logic [31:0] core_sx   = '0;
  logic [31:0] core_sy   = '0;

  always @(posedge clock) begin
    if (core_start) begin
      core_sx <= core_x;
      core_sy <= core_y;
      core_n  <= 1;
    end else if (core_enable) begin
      core_n <= core_n + 1;
      if (core_x !== core_sx || core_y !== core_sy) unstable <= unstable + 1;
    end
  end

  assign core_mod   = (core_n == NITER) ? ref_mod(core_sx, core_sy)   : 32'hDEAD_BEEF;
  assign core_angle = (core_n == NITER) ? ref_angle(core_sx, core_sy) : 32'hDEAD_BEEF;

  // Reference state: next round-robin start and last captured result.
  int          rr_next   = 0;
  logic [31:0] exp_mod   = '0;
  logic [31:0] exp_angle = '0;

  function automatic int exp_winner(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input int exp, input int tol);
    int d;
    d = $signed(obs) - exp;
    checks++;
    assert (d >= -tol && d <= tol) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    x_in[32*i +: 32] = x;
    y_in[32*i +: 32] = y;
  endtask

  task automatic rand_op(input int i);
    logic [31:0] x, y;
    case ($urandom_range(0, 7))
      0:       x = '0;
      1:       x = 32'h8000_0000 | 32'($urandom);
      2:       x = XMAX_DEF;
      default: x = 32'($urandom_range(1, 200 * 65536));
    endcase
    y = 32'(int'($urandom_range(0, 400 * 65536)) - 200 * 65536);
    set_op(i, x, y);
  endtask

  // Wait (bounded) for a grant and check it against the arbitration model.
  task automatic wait_gnt(output int w, output int wt, output logic [31:0] lx, output logic [31:0] ly);
    int ew;
    ew = exp_winner(req, rr_next);
    w  = -1;
    wt = 0;
    lx = '0;
    ly = '0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (gnt != '0) begin
        wt = i;
        break;
      end
    end
    check("gnt_seen", 64'(wt != 0), 64'(1));
    if (wt != 0) begin
      check("gnt_winner", 64'(gnt), 64'(1 << ew));
      w  = ew;
      lx = x_in[32*ew +: 32];
      ly = y_in[32*ew +: 32];
`ifdef CORDIC_SCHED_RR_EN
      rr_next = (ew + 1) % NREQ;
`endif
    end
  endtask

  // Follow one granted operation to its response and check timing and results.
  task automatic finish_txn(input int w, input logic [31:0] lx, input logic [31:0] ly,
                            input bit keep, input logic [NREQ-1:0] clr1,
                            input logic [NREQ-1:0] set1, input bit scramble);
    bit legal, start_ok, seq_ok;
    int last, en_cnt, start_cnt;
    legal     = ($signed(lx) > 0) && ($signed(lx) < $signed(XMAX_DEF));
    last      = legal ? NITER + 2 : 2;
    en_cnt    = 0;
    start_cnt = 0;
    start_ok  = 1'b0;
    seq_ok    = 1'b1;
    for (int k = 1; k <= last; k++) begin
      cycle();
      if (core_enable) en_cnt++;
      if (core_start) start_cnt++;
      if (k == 1) start_ok = (core_start === legal);
      if (k < last && (gnt !== '0 || rsp_valid !== '0 || busy !== 1'b1)) seq_ok = 1'b0;
      if (k < last && legal && (core_x !== lx || core_y !== ly)) seq_ok = 1'b0;
      if (k == 1) begin
        req = (req & clr1) | set1;
        if (scramble) for (int i = 0; i < NREQ; i++) rand_op(i);
      end
    end
    if (legal) begin
      exp_mod   = ref_mod(lx, ly);
      exp_angle = ref_angle(lx, ly);
    end
    check("start_timing", 64'(start_ok), 64'(1));
    check("start_count", 64'(start_cnt), 64'(legal ? 1 : 0));
    check("enable_cycles", 64'(en_cnt), 64'(legal ? NITER : 0));
    check("quiet_while_busy", 64'(seq_ok), 64'(1));
    check("rsp_valid", 64'(rsp_valid), 64'(1 << w));
    check("rsp_err", 64'(rsp_err), 64'(!legal));
    check("busy_at_rsp", 64'(busy), 64'(0));
    check("mod_angle", {mod_out, angle_out}, {exp_mod, exp_angle});
    if (!keep) req[w] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wt;
    logic [31:0] lx, ly;
    int exp_seq [6];
    bit held;

    reset = 1'b0;
    req   = '0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) cycle();
    check("rst_results", {mod_out, angle_out}, 64'(0));
    check("rst_core_xy", {core_x, core_y}, 64'(0));
    check("rst_ctrl", 64'({gnt, rsp_valid, rsp_err, busy, core_start, core_enable}), 64'(0));
    reset = 1'b1;
    repeat (3) cycle();
    check("idle_no_req", 64'({gnt, busy}), 64'(0));

    // Single request 3+4j.
    set_op(0, 32'h0003_0000, 32'h0004_0000);
    req = 4'b0001;
    wait_gnt(w, wt, lx, ly);
    check("single_gnt_latency", 64'(wt), 64'(1));
    if (w >= 0) finish_txn(w, lx, ly, 1'b0, '1, '0, 1'b0);
    check("single_mod", 64'(mod_out), 64'(32'h0005_0000));
    check_near("single_angle", angle_out, $rtoi(53.13010235 * 16777216.0), 4096);

    // All four requesting, held across rounds.
`ifdef CORDIC_SCHED_RR_EN
    exp_seq = '{0, 1, 2, 3, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < NREQ; i++) set_op(i, 32'((i + 1) * 65536), 32'(i * 32768));
    req = 4'b1111;
    for (int r = 0; r < 6; r++) begin
      wait_gnt(w, wt, lx, ly);
      check("rounds_spacing", 64'(wt), 64'(1));
      check("rounds_order", 64'(w), 64'(exp_seq[r]));
      if (w >= 0) finish_txn(w, lx, ly, 1'b1, '1, '0, 1'b0);
    end
    req = '0;
    cycle();

    // Illegal and boundary x operands.
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: set_op(1, 32'h0000_0000, 32'h0001_0000);
        1: set_op(1, 32'h8000_0000, 32'h0001_0000);
        2: set_op(1, XMAX_DEF, 32'h0000_0000);
        3: set_op(1, XMAX_DEF - 32'd1, 32'h0000_0000);
        default: set_op(1, 32'h0000_0001, 32'h0000_0000);
      endcase
      req = 4'b0010;
      wait_gnt(w, wt, lx, ly);
      if (w >= 0) finish_txn(w, lx, ly, 1'b0, '1, '0, 1'b0);
    end

    // Requester 2 withdraws right after its grant while 0 becomes pending.
    set_op(2, 32'h0002_0000, 32'h0002_0000);
    set_op(0, 32'h0000_8000, 32'hFFFF_8000);
    req = 4'b0100;
    wait_gnt(w, wt, lx, ly);
    check("drop_winner", 64'(w), 64'(2));
    if (w >= 0) finish_txn(w, lx, ly, 1'b0, 4'b1011, 4'b0001, 1'b0);
    wait_gnt(w, wt, lx, ly);
    check("drop_next_pending", 64'(w), 64'(0));
    if (w >= 0) finish_txn(w, lx, ly, 1'b0, '1, '0, 1'b0);

    // Reset while running with the counter at 10.
    set_op(3, 32'h0002_0000, 32'h0001_0000);
    req = 4'b1000;
    wait_gnt(w, wt, lx, ly);
    repeat (NITER - 10) cycle();
    reset = 1'b0;
    #1;
    check("abort_results", {mod_out, angle_out}, 64'(0));
    check("abort_core_xy", {core_x, core_y}, 64'(0));
    check("abort_ctrl", 64'({gnt, rsp_valid, rsp_err, busy, core_start, core_enable}), 64'(0));
    held = 1'b1;
    repeat (3) begin
      cycle();
      if (rsp_valid !== '0) held = 1'b0;
    end
    check("abort_no_rsp", 64'(held), 64'(1));
    rr_next   = 0;
    exp_mod   = '0;
    exp_angle = '0;
    reset     = 1'b1;
    wait_gnt(w, wt, lx, ly);
    check("post_reset_gnt", 64'(w), 64'(3));
    if (w >= 0) finish_txn(w, lx, ly, 1'b0, '1, '0, 1'b0);

    // 1 - 1j: negative angle.
    set_op(1, Q16_ONE, 32'(-int'(Q16_ONE)));
    req = 4'b0010;
    wait_gnt(w, wt, lx, ly);
    if (w >= 0) finish_txn(w, lx, ly, 1'b0, '1, '0, 1'b1);
    check_near("neg45_angle", angle_out, -45 * int'(Q24_ONE), 256);
    check_near("neg45_mod", mod_out, $rtoi(1.41421356 * 65536.0), 16);

    // Randomized traffic against the reference.
    req = '0;
    for (int r = 0; r < 20; r++) begin
      if (req == '0) begin
        for (int i = 0; i < NREQ; i++) rand_op(i);
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      end
      wait_gnt(w, wt, lx, ly);
      if (w >= 0) finish_txn(w, lx, ly, 1'($urandom_range(0, 1)), '1,
                             NREQ'($urandom_range(0, (1 << NREQ) - 1)), 1'b1);
    end
    req = '0;
    repeat (2) cycle();
    check("core_xy_stable", 64'(unstable), 64'(0));
    check("final_idle", 64'({gnt, rsp_valid, busy}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
